// File: rtl/dmem_responder.sv
// dmem_responder: single-cycle data-memory responder for the CPU's external
// data port. It serves a word RAM and an MMIO page at addr[31:28] == 4'hF
// that holds a TX byte FIFO, an RX byte FIFO, STATUS and a cycle counter.
//
// Optional build macro: DMEM_ALIGN_CHECK_EN
//   defined   : accesses with addr[1:0] != 0 have no effect, read 0 and set
//               the sticky misalign flag (STATUS[5]) when they commit.
//   undefined : addr[1:0] is ignored and STATUS[5] reads 0.
//
// Handshake: the TX byte at tx_data leaves the FIFO on every rising edge
// where tx_valid & tx_ready; tx_valid never depends on tx_ready, and
// tx_data/tx_valid only change after a transfer or a push. rx_valid has no
// backpressure: a byte arriving while the RX FIFO is full (and not being
// popped that cycle) is dropped and sets the sticky overrun flag.
module dmem_responder #(
    parameter int RAM_AW   = 12,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_mem_en,
    input  logic        data_mem_wr,
    input  logic [31:0] data_mem_addr,
    input  logic [31:0] data_mem_write_data,
    input  logic        cpu_stall,
    output logic [31:0] data_mem_data,
    output logic        mem_stall,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_PW + 1;
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_PW + 1;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_RXDATA = 2'd1,
        REG_STATUS = 2'd2,
        REG_CYCLE  = 2'd3
    } reg_sel_e;

    // Storage
    logic [31:0]      ram [0:(1 << RAM_AW) - 1];
    logic [7:0]       tx_mem [0:TX_DEPTH - 1];
    logic [7:0]       rx_mem [0:RX_DEPTH - 1];
    logic [TX_PW-1:0] tx_wptr;
    logic [TX_PW-1:0] tx_rptr;
    logic [TX_CW-1:0] tx_count;
    logic [RX_PW-1:0] rx_wptr;
    logic [RX_PW-1:0] rx_rptr;
    logic [RX_CW-1:0] rx_count;
    logic             overrun;
    logic [31:0]      cycle_count;

    // Decode and qualifiers
    logic              is_mmio;
    reg_sel_e          reg_sel;
    logic [RAM_AW-1:0] ram_word;
    logic              misaligned;
    logic              misalign_flag;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_full;
    logic              rx_empty;
    logic              commit;
    logic              wr_commit;
    logic              rd_commit;
    logic              ram_we;
    logic              tx_push;
    logic              tx_pop;
    logic              rx_push;
    logic              rx_pop;
    logic              overrun_set;
    logic              misalign_set;
    logic              status_wr;
    logic              cycle_wr;
    logic [31:0]       status_word;
    logic              unused_addr_bits;

    assign is_mmio  = (data_mem_addr[31:28] == 4'hF);
    assign reg_sel  = reg_sel_e'(data_mem_addr[3:2]);
    assign ram_word = data_mem_addr[RAM_AW+1:2];

    // Address bits that alias in RAM space, plus the byte offset when it is not checked.
    assign unused_addr_bits = ^{data_mem_addr[27:RAM_AW+2], data_mem_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned   = data_mem_en & (data_mem_addr[1:0] != 2'b00);
    assign misalign_set = commit & misaligned;
`else
    assign misaligned   = 1'b0;
    assign misalign_set = 1'b0;
`endif

    assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_count == '0);

    // A TXDATA write to a full FIFO holds the pipeline; a pop in the same
    // cycle is deliberately not considered so the stall path stays short.
    assign mem_stall = data_mem_en & data_mem_wr & is_mmio & (reg_sel == REG_TXDATA)
                     & tx_full & ~misaligned;

    assign commit    = data_mem_en & ~cpu_stall & ~mem_stall;
    assign wr_commit = commit & data_mem_wr & ~misaligned;
    assign rd_commit = commit & ~data_mem_wr & ~misaligned;

    assign ram_we      = wr_commit & ~is_mmio;
    assign tx_push     = wr_commit & is_mmio & (reg_sel == REG_TXDATA);
    assign tx_pop      = tx_valid & tx_ready;
    assign rx_pop      = rd_commit & is_mmio & (reg_sel == REG_RXDATA) & ~rx_empty;
    assign rx_push     = rx_valid & (~rx_full | rx_pop);
    assign overrun_set = rx_valid & rx_full & ~rx_pop;
    assign status_wr   = wr_commit & is_mmio & (reg_sel == REG_STATUS);
    assign cycle_wr    = wr_commit & is_mmio & (reg_sel == REG_CYCLE);

    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr];

    // Assemble the STATUS register from live FIFO state and sticky flags.
    always_comb begin
        status_word        = '0;
        status_word[0]     = tx_full;
        status_word[1]     = tx_empty;
        status_word[2]     = rx_empty;
        status_word[3]     = rx_full;
        status_word[4]     = overrun;
        status_word[5]     = misalign_flag;
        status_word[15:8]  = 8'(tx_count);
        status_word[23:16] = 8'(rx_count);
    end

    // Combinational read mux; writes and idle cycles return 0.
    always_comb begin
        data_mem_data = '0;
        if (data_mem_en && !data_mem_wr && !misaligned) begin
            if (!is_mmio) begin
                data_mem_data = ram[ram_word];
            end else begin
                case (reg_sel)
                    REG_RXDATA: data_mem_data = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rptr]};
                    REG_STATUS: data_mem_data = status_word;
                    REG_CYCLE:  data_mem_data = cycle_count;
                    default:    data_mem_data = '0;
                endcase
            end
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_word] <= data_mem_write_data;
        end
    end

    // TX FIFO storage.
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= data_mem_write_data[7:0];
        end
    end

    // TX FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_wptr <= tx_wptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + 1'b1;
            end
            if (tx_push && !tx_pop) begin
                tx_count <= tx_count + 1'b1;
            end else if (!tx_push && tx_pop) begin
                tx_count <= tx_count - 1'b1;
            end
        end
    end

    // RX FIFO storage.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wptr] <= rx_data;
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_wptr <= rx_wptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + 1'b1;
            end
            if (rx_push && !rx_pop) begin
                rx_count <= rx_count + 1'b1;
            end else if (!rx_push && rx_pop) begin
                rx_count <= rx_count - 1'b1;
            end
        end
    end

    // Sticky overrun flag: write-one-to-clear, a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end else if (status_wr && data_mem_write_data[4]) begin
            overrun <= 1'b0;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Sticky misalign flag: write-one-to-clear, a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_flag <= 1'b0;
        end else if (misalign_set) begin
            misalign_flag <= 1'b1;
        end else if (status_wr && data_mem_write_data[5]) begin
            misalign_flag <= 1'b0;
        end
    end
`else
    assign misalign_flag = misalign_set;
`endif

    // Free-running cycle counter; a write loads the value so that the next
    // cycle already reads write_data + 1, as if it had kept counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if (cycle_wr) begin
            cycle_count <= data_mem_write_data + 32'd1;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scenarios plus randomized traffic for
// dmem_responder, checked every cycle against a queue-based reference model.
module tb_dmem_responder;

    localparam int RAM_AW = 12;
    localparam int TXD    = 16;
    localparam int RXD    = 16;

    localparam logic [31:0] A_TX  = 32'hF000_0000;
    localparam logic [31:0] A_RX  = 32'hF000_0004;
    localparam logic [31:0] A_ST  = 32'hF000_0008;
    localparam logic [31:0] A_CYC = 32'hF000_000C;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT inputs
    logic        en   = 1'b0;
    logic        wr   = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wd   = '0;
    logic        cs   = 1'b0;
    logic        rdy  = 1'b0;
    logic        rxv  = 1'b0;
    logic [7:0]  rxd  = '0;

    // DUT outputs
    logic [31:0] data_mem_data;
    logic        mem_stall;
    logic [7:0]  tx_data;
    logic        tx_valid;

    dmem_responder #(
        .RAM_AW   (RAM_AW),
        .TX_DEPTH (TXD),
        .RX_DEPTH (RXD)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .data_mem_en         (en),
        .data_mem_wr         (wr),
        .data_mem_addr       (addr),
        .data_mem_write_data (wd),
        .cpu_stall           (cs),
        .data_mem_data       (data_mem_data),
        .mem_stall           (mem_stall),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_ready            (rdy),
        .rx_data             (rxd),
        .rx_valid            (rxv)
    );

    // Reference model state
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic [31:0] ram_m[int];
    bit          ovr_m;
    bit          mis_m;
    logic [31:0] cyc_m;

    // Scoreboard counters and last observed values
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] obs_data;
    logic        obs_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (txq.size() == TXD);
        s[1]     = (txq.size() == 0);
        s[2]     = (rxq.size() == 0);
        s[3]     = (rxq.size() == RXD);
        s[4]     = ovr_m;
        s[5]     = mis_m;
        s[15:8]  = 8'(txq.size());
        s[23:16] = 8'(rxq.size());
        return s;
    endfunction

    task automatic drive(input logic e, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic s);
        en   = e;
        wr   = w;
        addr = a;
        wd   = d;
        cs   = s;
    endtask

    // One clock cycle: check outputs against the model mid-cycle, then advance the model.
    task automatic step();
        logic        mmio;
        logic [1:0]  sel;
        logic        mis;
        logic        exp_stall;
        logic [31:0] exp_data;
        logic        known;
        int          key;
        logic        commit;
        logic        wc;
        logic        rc;
        logic        rx_full_b;
        logic        popped;
        logic        ovr_set;

        #2;
        mmio = (addr[31:28] == 4'hF);
        sel  = addr[3:2];
        key  = int'(addr[RAM_AW+1:2]);
`ifdef DMEM_ALIGN_CHECK_EN
        mis = en && (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        exp_stall = en && wr && mmio && (sel == 2'd0) && (txq.size() == TXD) && !mis;
        exp_data  = '0;
        known     = 1'b1;
        if (en && !wr && !mis) begin
            if (!mmio) begin
                known = ram_m.exists(key);
                if (known) exp_data = ram_m[key];
            end else begin
                case (sel)
                    2'd1:    exp_data = (rxq.size() != 0) ? {24'h0, rxq[0]} : 32'h0;
                    2'd2:    exp_data = model_status();
                    2'd3:    exp_data = cyc_m;
                    default: exp_data = '0;
                endcase
            end
        end

        obs_data  = data_mem_data;
        obs_stall = mem_stall;
        check("mem_stall", {31'h0, mem_stall}, {31'h0, exp_stall});
        if (known) check("read_data", data_mem_data, exp_data);
        check("tx_valid", {31'h0, tx_valid}, {31'h0, (txq.size() != 0)});
        if (txq.size() != 0) check("tx_data", {24'h0, tx_data}, {24'h0, txq[0]});

        @(posedge clk);
        if (rst) begin
            txq.delete();
            rxq.delete();
            ovr_m = 1'b0;
            mis_m = 1'b0;
            cyc_m = '0;
        end else begin
            commit    = en && !cs && !exp_stall;
            wc        = commit && wr && !mis;
            rc        = commit && !wr && !mis;
            rx_full_b = (rxq.size() == RXD);
            popped    = 1'b0;
            ovr_set   = 1'b0;
            if (txq.size() != 0 && rdy) void'(txq.pop_front());
            if (wc && mmio && sel == 2'd0) txq.push_back(wd[7:0]);
            if (rc && mmio && sel == 2'd1 && rxq.size() != 0) begin
                void'(rxq.pop_front());
                popped = 1'b1;
            end
            if (rxv) begin
                if (!rx_full_b || popped) rxq.push_back(rxd);
                else ovr_set = 1'b1;
            end
            if (wc && mmio && sel == 2'd2) begin
                if (wd[4]) ovr_m = 1'b0;
                if (wd[5]) mis_m = 1'b0;
            end
            if (ovr_set) ovr_m = 1'b1;
            if (commit && mis) mis_m = 1'b1;
            if (wc && mmio && sel == 2'd3) cyc_m = wd + 32'd1;
            else cyc_m = cyc_m + 32'd1;
            if (wc && !mmio) ram_m[key] = wd;
        end
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] st_before;
        int          kind;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        txq.delete();
        rxq.delete();
        ovr_m = 1'b0;
        mis_m = 1'b0;
        cyc_m = '0;

        drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
        step();
        check("reset_status", obs_data, 32'h0000_0006);
        check("reset_stall", {31'h0, obs_stall}, 32'h0);
        drive(1'b1, 1'b0, A_CYC, 32'h0, 1'b0);
        step();
        check("reset_cycle", obs_data, 32'h0000_0001);

        // RAM write/read, then reset leaves RAM intact
        drive(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
        step();
        check("ram_read", obs_data, 32'h1234_5678);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
        step();
        check("ram_after_reset", obs_data, 32'h1234_5678);

        // TX fill to depth, 17th write stalls until one pop frees a slot
        rdy = 1'b0;
        for (int i = 0; i < TXD; i++) begin
            drive(1'b1, 1'b1, A_TX, 32'(i + 8'h30), 1'b0);
            step();
        end
        drive(1'b1, 1'b1, A_TX, 32'h0000_00AA, 1'b0);
        step();
        check("tx_stall_17th", {31'h0, obs_stall}, 32'h1);
        rdy = 1'b1;
        step();
        check("tx_stall_pop_cycle", {31'h0, obs_stall}, 32'h1);
        rdy = 1'b0;
        step();
        check("tx_stall_drop", {31'h0, obs_stall}, 32'h0);
        drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
        step();
        check("tx_count_16", {24'h0, obs_data[15:8]}, 32'd16);
        check("tx_full_bit", {31'h0, obs_data[0]}, 32'h1);
        rdy = 1'b1;
        for (int i = 0; i < TXD + 2; i++) idle();
        rdy = 1'b0;

        // RX overrun, read head, W1C of overrun
        for (int i = 1; i <= 17; i++) begin
            rxv = 1'b1;
            rxd = 8'(i);
            idle();
        end
        rxv = 1'b0;
        drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
        step();
        check("rx_count_16", {24'h0, obs_data[23:16]}, 32'd16);
        check("rx_overrun", {31'h0, obs_data[4]}, 32'h1);
        drive(1'b1, 1'b0, A_RX, 32'h0, 1'b0);
        step();
        check("rx_head", obs_data, 32'h0000_0001);
        drive(1'b1, 1'b1, A_ST, 32'h0000_0010, 1'b0);
        step();
        drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
        step();
        check("overrun_w1c", {31'h0, obs_data[4]}, 32'h0);

        // RX read held by cpu_stall pops exactly once
        st_before = obs_data;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, A_RX, 32'h0, 1'b1);
            step();
        end
        drive(1'b1, 1'b0, A_RX, 32'h0, 1'b0);
        step();
        check("rx_stalled_data", obs_data, 32'h0000_0002);
        drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
        step();
        check("rx_one_pop", {24'h0, obs_data[23:16]}, {24'h0, st_before[23:16] - 8'd1});

        // CYCLE load and wrap
        drive(1'b1, 1'b1, A_CYC, 32'hFFFF_FFFE, 1'b0);
        step();
        drive(1'b1, 1'b0, A_CYC, 32'h0, 1'b0);
        step();
        check("cycle_load", obs_data, 32'hFFFF_FFFF);
        step();
        check("cycle_wrap", obs_data, 32'h0000_0000);

        // Unaligned write
        drive(1'b1, 1'b1, 32'h0000_0042, 32'hCAFE_F00D, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
        step();
`ifdef DMEM_ALIGN_CHECK_EN
        check("misalign_no_write", obs_data, 32'h1234_5678);
        drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
        step();
        check("misalign_flag", {31'h0, obs_data[5]}, 32'h1);
`else
        check("unaligned_write", obs_data, 32'hCAFE_F00D);
`endif

        // Reset while a TXDATA write is stalled drops that write
        rdy = 1'b0;
        for (int i = 0; i < TXD; i++) begin
            drive(1'b1, 1'b1, A_TX, 32'(i), 1'b0);
            step();
        end
        drive(1'b1, 1'b1, A_TX, 32'h0000_0055, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, A_ST, 32'h0, 1'b0);
        step();
        check("reset_mid_stall", obs_data, 32'h0000_0006);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rdy  = ($urandom_range(0, 1) == 1);
            rxv  = ($urandom_range(0, 9) < 3);
            rxd  = 8'($urandom);
            kind = $urandom_range(0, 9);
            a    = $urandom;
            if (kind < 4) begin
                a[31:28]         = 4'($urandom_range(0, 14));
                a[RAM_AW+1:2]    = RAM_AW'($urandom_range(0, 7));
                a[1:0]           = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
                drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 1) == 1), a, $urandom,
                      ($urandom_range(0, 3) == 0));
            end else begin
                a[31:28] = 4'hF;
                a[1:0]   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
                case (kind)
                    4, 5:    a[3:2] = 2'd0;
                    6:       a[3:2] = 2'd1;
                    7, 8:    a[3:2] = 2'd2;
                    default: a[3:2] = 2'd3;
                endcase
                drive(($urandom_range(0, 9) < 8),
                      (a[3:2] == 2'd0) ? 1'b1 :
                      (a[3:2] == 2'd1) ? ($urandom_range(0, 9) == 0) :
                      ($urandom_range(0, 4) == 0),
                      a, $urandom, ($urandom_range(0, 3) == 0));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
